// File: rtl/uart_rx_deframer_if.sv
// Byte output channel of the UART receive deframer.
// The deframer drives the master side. The downstream byte consumer takes the slave side.
interface uart_rx_deframer_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: start-bit validation, mid-bit data sampling and stop-bit check.
// Each completed byte is presented on a valid/ready channel, with framing and overrun strobes.
module uart_rx_deframer #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_tick,
  input  logic               rx,
  uart_rx_deframer_if.master byte_if,
  output logic               framing_err,
  output logic               overrun_err,
  output logic               busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state_q;
  logic                   sync1_q, rxs_q;
  logic [TICK_W-1:0]      tick_q;
  logic [BIT_W-1:0]       bit_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   done_q, frm_q, busy_q;
  logic [DATA_BITS-1:0]   data_q;
  logic                   valid_q, ovr_q;

  // Two-flop synchronizer; resets to the idle-high line level so reset never looks like a start bit.
  // NOTE: every clocked register uses non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rx;
      rxs_q   <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
      frm_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      frm_q  <= 1'b0;
      if (sample_tick) begin
        case (state_q)
          S_IDLE: begin
            if (!rxs_q) begin
              state_q <= S_START;
              tick_q  <= '0;
              busy_q  <= 1'b1;
            end
          end
          S_START: begin
            if (tick_q == HALF_LAST) begin
              tick_q <= '0;
              bit_q  <= '0;
              if (!rxs_q) begin
                state_q <= S_DATA;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              tick_q <= tick_q + TICK_W'(1);
            end
          end
          S_DATA: begin
            if (tick_q == TICK_LAST) begin
              shift_q <= {rxs_q, shift_q[DATA_BITS-1:1]};
              bit_q   <= bit_q + BIT_W'(1);
              tick_q  <= '0;
              if (bit_q == BIT_LAST) state_q <= S_STOP;
            end else begin
              tick_q <= tick_q + TICK_W'(1);
            end
          end
          S_STOP: begin
            if (tick_q == TICK_LAST) begin
              tick_q <= '0;
              if (rxs_q) begin
                done_q  <= 1'b1;
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end else begin
                frm_q   <= 1'b1;
                state_q <= S_BREAK;
              end
            end else begin
              tick_q <= tick_q + TICK_W'(1);
            end
          end
          S_BREAK: begin
            // Wait for the line to return high so a held-low line cannot retrigger a frame.
            if (rxs_q) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Output handshake. A byte completing in the same clk as an accept replaces the accepted byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (done_q) begin
        if (!valid_q || byte_if.rx_ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && byte_if.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign byte_if.rx_data  = data_q;
  assign byte_if.rx_valid = valid_q;
  assign framing_err      = frm_q;
  assign overrun_err      = ovr_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed self-checking bench for uart_rx_deframer (DATA_BITS=8, OVERSAMPLE=16).
// Sample ticks come from a programmable divider. Outputs are sampled on the falling clock edge.
module tb_uart_rx_deframer;

  localparam int DB = 8;
  localparam int OS = 16;

  logic clk = 1'b0;
  logic reset;
  logic sample_tick = 1'b0;
  logic rx;
  logic framing_err, overrun_err, busy;

  uart_rx_deframer_if #(.DATA_BITS(DB)) bif ();

  uart_rx_deframer #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .rx          (rx),
    .byte_if     (bif),
    .framing_err (framing_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Tick divider: sample_tick is high for one clk out of every tick_div clks.
  int tick_div = 3;
  int div_cnt  = 0;
  always @(negedge clk) begin
    if (div_cnt >= tick_div - 1) begin
      div_cnt     = 0;
      sample_tick = 1'b1;
    end else begin
      div_cnt     = div_cnt + 1;
      sample_tick = 1'b0;
    end
  end

  // Event monitors
  int          acc_cnt = 0, vld_cyc = 0, frm_cnt = 0, ovr_cnt = 0;
  logic [7:0]  acc_data = '0;
  always @(negedge clk) begin
    if (!reset) begin
      if (bif.rx_valid) vld_cyc = vld_cyc + 1;
      if (bif.rx_valid && bif.rx_ready) begin
        acc_cnt  = acc_cnt + 1;
        acc_data = bif.rx_data;
      end
      if (framing_err) frm_cnt = frm_cnt + 1;
      if (overrun_err) ovr_cnt = ovr_cnt + 1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int acc0, vld0, frm0, ovr0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n sample ticks, then stop 1 time unit after the last ticked edge.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!sample_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    ticks(OS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    ticks(n * OS);
  endtask

  task automatic snap();
    acc0 = acc_cnt;
    vld0 = vld_cyc;
    frm0 = frm_cnt;
    ovr0 = ovr_cnt;
  endtask

  initial begin
    reset        = 1'b1;
    rx           = 1'b1;
    bif.rx_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("reset_valid", 32'(bif.rx_valid), 32'd0);
    check("reset_data", 32'(bif.rx_data), 32'h00);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_errs", 32'({framing_err, overrun_err}), 32'd0);
    reset = 1'b0;
    idle_bits(1);

    // Single frame 0xA5 with the consumer always ready
    snap();
    send_frame(8'hA5, 1'b1);
    idle_bits(2);
    check("a5_accepts", 32'(acc_cnt - acc0), 32'd1);
    check("a5_data", 32'(acc_data), 32'hA5);
    check("a5_valid_cycles", 32'(vld_cyc - vld0), 32'd1);
    check("a5_errs", 32'((frm_cnt - frm0) + (ovr_cnt - ovr0)), 32'd0);
    check("a5_busy_after", 32'(busy), 32'd0);

    // Start-bit glitch of 4 ticks, then a valid 0x3C frame
    snap();
    rx = 1'b0;
    ticks(4);
    idle_bits(2);
    check("glitch_accepts", 32'(acc_cnt - acc0), 32'd0);
    check("glitch_frm", 32'(frm_cnt - frm0), 32'd0);
    check("glitch_busy", 32'(busy), 32'd0);
    send_frame(8'h3C, 1'b1);
    idle_bits(2);
    check("3c_accepts", 32'(acc_cnt - acc0), 32'd1);
    check("3c_data", 32'(acc_data), 32'h3C);

    // Framing error followed by a 40-bit break, then recovery with 0x55
    snap();
    send_frame(8'h00, 1'b0);
    rx = 1'b0;
    ticks(40 * OS);
    check("brk_frm_pulses", 32'(frm_cnt - frm0), 32'd1);
    check("brk_accepts", 32'(acc_cnt - acc0), 32'd0);
    check("brk_busy", 32'(busy), 32'd1);
    check("brk_valid", 32'(bif.rx_valid), 32'd0);
    idle_bits(2);
    check("brk_busy_after", 32'(busy), 32'd0);
    send_frame(8'h55, 1'b1);
    idle_bits(2);
    check("55_accepts", 32'(acc_cnt - acc0), 32'd1);
    check("55_data", 32'(acc_data), 32'h55);
    check("55_no_new_frm", 32'(frm_cnt - frm0), 32'd1);

    // Overrun: consumer stalled across two back-to-back frames
    snap();
    bif.rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle_bits(2);
    check("ovr_valid", 32'(bif.rx_valid), 32'd1);
    check("ovr_data_kept", 32'(bif.rx_data), 32'h11);
    check("ovr_pulses", 32'(ovr_cnt - ovr0), 32'd1);
    check("ovr_frm", 32'(frm_cnt - frm0), 32'd0);
    bif.rx_ready = 1'b1;
    @(posedge clk);
    #1;
    bif.rx_ready = 1'b0;
    check("ovr_drain_valid", 32'(bif.rx_valid), 32'd0);
    check("ovr_drain_accepts", 32'(acc_cnt - acc0), 32'd1);
    check("ovr_drain_data", 32'(acc_data), 32'h11);

    // Accept coinciding with completion, sample_tick tied high (one tick per clk).
    // Completion clk is the 12th edge after the last data bit ends: 3 clks for sync and detect,
    // 8 for the start half-bit, 16 per data bit, and 16 for the stop sample, plus one.
    tick_div = 1;
    idle_bits(2);
    send_frame(8'h11, 1'b1);
    idle_bits(2);
    check("coin_pending", 32'({bif.rx_valid, bif.rx_data}), 32'h111);
    snap();
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(1'((8'h22 >> i) & 8'h01));
    rx = 1'b1;
    ticks(11);
    bif.rx_ready = 1'b1;
    ticks(1);
    bif.rx_ready = 1'b0;
    check("coin_no_ovr", 32'(ovr_cnt - ovr0), 32'd0);
    check("coin_valid", 32'(bif.rx_valid), 32'd1);
    check("coin_data", 32'(bif.rx_data), 32'h22);
    check("coin_accepts", 32'(acc_cnt - acc0), 32'd1);
    idle_bits(1);
    bif.rx_ready = 1'b1;
    ticks(2);

    // Reset in the middle of data bit 4 of 0xF0, then receive 0x81
    tick_div = 3;
    idle_bits(1);
    snap();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rx = 1'b1;
    ticks(8);
    check("rst_mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_out_valid", 32'(bif.rx_valid), 32'd0);
    check("rst_out_data", 32'(bif.rx_data), 32'h00);
    check("rst_out_busy", 32'(busy), 32'd0);
    check("rst_out_errs", 32'({framing_err, overrun_err}), 32'd0);
    ticks(8);
    for (int i = 5; i < DB; i++) send_bit(1'b1);
    idle_bits(3);
    check("rst_no_byte", 32'(acc_cnt - acc0), 32'd0);
    check("rst_no_err", 32'((frm_cnt - frm0) + (ovr_cnt - ovr0)), 32'd0);
    send_frame(8'h81, 1'b1);
    idle_bits(2);
    check("81_accepts", 32'(acc_cnt - acc0), 32'd1);
    check("81_data", 32'(acc_data), 32'h81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
Serial-to-parallel UART receive stage. It sits directly downstream of the baud/sample generator and consumes its oversampling tick plus the raw RX line. It detects and validates the start bit, samples each data bit at mid-bit, and checks the stop bit. Completed bytes go out on a valid/ready interface to the byte consumer (FIFO or command parser), with framing and overrun error strobes.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), LSB first, no parity
OVERSAMPLE, 16, sample ticks per bit period (even, >= 4)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
sample_tick  input  1  one-clk-wide strobe from the baud generator, OVERSAMPLE per bit
rx  input  1  asynchronous serial line, idle high
rx_data  output  DATA_BITS  received byte, stable while rx_valid=1
rx_valid  output  1  byte available; held until accepted
rx_ready  input  1  consumer accepts rx_data when rx_valid&rx_ready at clk edge
framing_err  output  1  one-clk pulse: stop bit sampled low
overrun_err  output  1  one-clk pulse: byte completed while previous not accepted
busy  output  1  high in any state other than IDLE

Behaviour:
- rx passes through a 2-FF synchronizer, reset value 1; all decisions use the synchronized value rxs (2 clk latency).
- Tick counter width = clog2(OVERSAMPLE); bit counter width = clog2(DATA_BITS+1). Both advance only on clk edges where sample_tick=1.
- Reset values: rx_data=0, rx_valid=0, framing_err=0, overrun_err=0, busy=0, state=IDLE, counters=0, sync FFs=1.
- Reset has priority over every other event. A mid-frame reset discards the partial byte and returns to IDLE.
- IDLE: on a tick with rxs=0, go to START with tick_cnt=0.
- START: count ticks. On the tick where tick_cnt reaches OVERSAMPLE/2-1:
  - rxs=0: go to DATA, tick_cnt=0, bit_cnt=0.
  - rxs=1: glitch; go to IDLE with no output and no error.
- DATA: on the tick where tick_cnt reaches OVERSAMPLE-1, sample rxs into shift register MSB, shift right (LSB first), bit_cnt+1, tick_cnt=0. After DATA_BITS samples, go to STOP.
- STOP: on the tick where tick_cnt reaches OVERSAMPLE-1, sample rxs:
  - rxs=1: byte complete; go to IDLE.
  - rxs=0: framing_err=1 for one clk, byte discarded, rx_valid unaffected; go to BREAK.
- BREAK: wait until a tick with rxs=1, then go to IDLE. This prevents a held-low line from retriggering.
- Byte completion, on the clk after the stop-sample tick:
  - rx_valid=0, or rx_valid=1 and rx_ready=1 in the same cycle: load rx_data, rx_valid=1 (the accept and the new load coincide; nothing is lost).
  - rx_valid=1 and rx_ready=0: new byte dropped, old rx_data kept, overrun_err=1 for one clk.
- Accept: rx_valid&rx_ready with no completion in that cycle clears rx_valid next clk.
- rx_ready while rx_valid=0 has no effect.
- framing_err and overrun_err never assert in the same clk (they come from distinct stop outcomes).
- Frame-to-frame: in IDLE, a falling edge seen on the first tick after the stop sample starts the next frame. Back-to-back frames with a 1-bit stop are supported.
- No behaviour depends on clk cycles between ticks. Ticks spaced 1 clk apart (sample_tick tied high) must also work.

Test Plan:
- OVERSAMPLE=16, DATA_BITS=8, rx_ready=1; send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> rx_valid pulses 1 clk with rx_data=0xA5; no errors; busy low afterwards.
- rx low for 4 ticks, then high -> no rx_valid, no framing_err; state returns to IDLE; a following 0x3C frame is received correctly.
- Send 0x00 with stop=0, then hold rx low for 40 bit times -> exactly one framing_err pulse, no rx_valid; after rx returns high, 0x55 is received correctly.
- rx_ready=0; send 0x11 then 0x22 back-to-back -> rx_valid=1, rx_data=0x11, one overrun_err at the end of the second frame; raising rx_ready for 1 clk clears rx_valid.
- rx_valid=1 (0x11 pending), rx_ready asserted exactly on the completion clk of 0x22 -> no overrun_err; rx_data=0x22, rx_valid stays 1.
- Assert reset for 1 clk during data bit 4 of 0xF0 -> outputs at reset values next clk; no byte or error from that frame; next frame 0x81 is received correctly.
